// File: rtl/holy_irq_pkg.sv
// Shared definitions for the interrupt arbiter: register offsets and the
// per-source gateway state encoding.
package holy_irq_pkg;

    localparam logic [7:0] IRQ_PRIO_BASE = 8'h00;
    localparam logic [7:0] IRQ_ENABLE    = 8'h40;
    localparam logic [7:0] IRQ_PENDING   = 8'h44;
    localparam logic [7:0] IRQ_THRESHOLD = 8'h48;
    localparam logic [7:0] IRQ_CLAIM     = 8'h4C;

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_t;

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway. Latches a level request, holds it until the
// handler claims it, and re-arms only after the matching completion. The
// source line is ignored while a request is pending or being serviced.
module irq_gateway
    import holy_irq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending,
    output logic inflight
);

    gw_state_t state_q;
    gw_state_t state_d;

    // Next-state logic for the IDLE -> PENDING -> INFLIGHT -> IDLE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GW_IDLE: begin
                if (src) begin
                    state_d = GW_PENDING;
                end else begin
                    state_d = GW_IDLE;
                end
            end
            GW_PENDING: begin
                if (claim_hit) begin
                    state_d = GW_INFLIGHT;
                end else begin
                    state_d = GW_PENDING;
                end
            end
            GW_INFLIGHT: begin
                if (complete_hit) begin
                    state_d = GW_IDLE;
                end else begin
                    state_d = GW_INFLIGHT;
                end
            end
            default: state_d = GW_IDLE;
        endcase
    end

    // Gateway state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign pending  = (state_q == GW_PENDING);
    assign inflight = (state_q == GW_INFLIGHT);

endmodule

// File: rtl/irq_arbiter.sv
// Platform interrupt arbiter: NUM_SRC gateways feed a priority/threshold
// arbiter whose registered winner drives the core's ext_itr. The handler
// claims the winner and completes it through a small register port.
module irq_arbiter
    import holy_irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               reg_req,
    input  logic               reg_we,
    input  logic [7:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_ack,
    output logic               ext_itr
);

    localparam int ID_W = 5;

    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [NUM_SRC-1:0]             enable_q, enable_d;
    logic [PRIO_W-1:0]              threshold_q, threshold_d;
    logic [ID_W-1:0]                best_id_q, best_id_d;
    logic                           ext_itr_q, ext_itr_d;
    logic                           reg_ack_q, reg_ack_d;
    logic [31:0]                    reg_rdata_q, reg_rdata_d;

    logic [NUM_SRC-1:0] pending_s;
    logic [NUM_SRC-1:0] inflight_s;
    logic [NUM_SRC-1:0] claim_hit_s;
    logic [NUM_SRC-1:0] complete_hit_s;
    logic [NUM_SRC-1:0] prio_sel_s;
    logic [PRIO_W-1:0]  prio_rd_s;
    logic [PRIO_W-1:0]  best_prio_s;
    logic [7:0]         word_addr_s;
    logic               rd_s;
    logic               wr_s;
    logic               unused_s;

    assign word_addr_s = {reg_addr[7:2], 2'b00};
    assign rd_s        = reg_req & ~reg_we;
    assign wr_s        = reg_req & reg_we;
    assign unused_s    = ^{reg_addr[1:0], reg_wdata};

    // Decode PRIO word selects and the matching read value; only the first
    // sixteen words belong to the PRIO window.
    always_comb begin
        prio_sel_s = '0;
        prio_rd_s  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            prio_sel_s[i] = (i < 16) && (word_addr_s == (IRQ_PRIO_BASE + 8'(4 * i)));
            prio_rd_s     = prio_rd_s | ({PRIO_W{prio_sel_s[i]}} & prio_q[i]);
        end
    end

    // Claim hits only if the registered winner is still pending, which makes
    // a back-to-back claim on a stale best_id_q return 0 with no effect.
    always_comb begin
        claim_hit_s    = '0;
        complete_hit_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_hit_s[i]    = rd_s && (word_addr_s == IRQ_CLAIM) &&
                                (best_id_q == ID_W'(i + 1)) && pending_s[i];
            complete_hit_s[i] = wr_s && (word_addr_s == IRQ_CLAIM) &&
                                (reg_wdata[ID_W-1:0] == ID_W'(i + 1)) && inflight_s[i];
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clk          (clk),
            .rst          (rst),
            .src          (src_irq[g]),
            .claim_hit    (claim_hit_s[g]),
            .complete_hit (complete_hit_s[g]),
            .pending      (pending_s[g]),
            .inflight     (inflight_s[g])
        );
    end

    // Arbiter: highest priority above threshold wins; strict compare keeps
    // the lowest ID on ties.
    always_comb begin
        best_id_d   = '0;
        best_prio_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending_s[i] && enable_q[i] && (prio_q[i] > threshold_q) &&
                (prio_q[i] > best_prio_s)) begin
                best_prio_s = prio_q[i];
                best_id_d   = ID_W'(i + 1);
            end else begin
                best_prio_s = best_prio_s;
            end
        end
        ext_itr_d = (best_id_d != '0);
    end

    // Configuration register writes take effect at the request edge.
    always_comb begin
        prio_d      = prio_q;
        enable_d    = enable_q;
        threshold_d = threshold_q;
        if (wr_s) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (prio_sel_s[i]) begin
                    prio_d[i] = reg_wdata[PRIO_W-1:0];
                end else begin
                    prio_d[i] = prio_q[i];
                end
            end
            if (word_addr_s == IRQ_ENABLE) begin
                enable_d = reg_wdata[NUM_SRC-1:0];
            end else begin
                enable_d = enable_q;
            end
            if (word_addr_s == IRQ_THRESHOLD) begin
                threshold_d = reg_wdata[PRIO_W-1:0];
            end else begin
                threshold_d = threshold_q;
            end
        end else begin
            prio_d      = prio_q;
            enable_d    = enable_q;
            threshold_d = threshold_q;
        end
    end

    // Read data mux; returns 0 for writes, idle cycles and unmapped offsets.
    always_comb begin
        reg_ack_d   = reg_req;
        reg_rdata_d = '0;
        if (rd_s) begin
            case (word_addr_s)
                IRQ_ENABLE:    reg_rdata_d = 32'(enable_q);
                IRQ_PENDING:   reg_rdata_d = 32'(pending_s);
                IRQ_THRESHOLD: reg_rdata_d = 32'(threshold_q);
                IRQ_CLAIM:     reg_rdata_d = (|claim_hit_s) ? 32'(best_id_q) : 32'd0;
                default:       reg_rdata_d = 32'(prio_rd_s);
            endcase
        end else begin
            reg_rdata_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= '0;
            enable_q    <= '0;
            threshold_q <= '0;
            best_id_q   <= '0;
            ext_itr_q   <= 1'b0;
            reg_ack_q   <= 1'b0;
            reg_rdata_q <= 32'd0;
        end else begin
            prio_q      <= prio_d;
            enable_q    <= enable_d;
            threshold_q <= threshold_d;
            best_id_q   <= best_id_d;
            ext_itr_q   <= ext_itr_d;
            reg_ack_q   <= reg_ack_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

    assign ext_itr   = ext_itr_q;
    assign reg_ack   = reg_ack_q;
    assign reg_rdata = reg_rdata_q;

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Platform-level interrupt arbiter that shares the core's single `ext_itr` input of the CSR file between NUM_SRC external peripheral interrupt lines.
- Per-source gateways latch requests. A priority/threshold arbiter selects the winner and drives `ext_itr`.
- The trap handler claims the winning ID over a memory-mapped register port, then signals completion to re-arm the source.
- Sits between peripherals and the core, on the SoC register bus.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31); source i has ID i+1, and ID 0 means "none".
- PRIO_W, 3, priority field width; priority 0 means the source never interrupts.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- src_irq  in  NUM_SRC  level-sensitive interrupt requests, already synchronous to clk
- reg_req  in  1  register access strobe, one cycle per access
- reg_we  in  1  1 = write, 0 = read
- reg_addr  in  8  byte offset, word aligned; bits [1:0] ignored
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, valid while reg_ack is high
- reg_ack  out  1  access acknowledge
- ext_itr  out  1  interrupt to the CSR file's ext_itr input

Behaviour:
- Register map (offsets):
  - 0x00+4*i: PRIO[i], RW, bits [PRIO_W-1:0]; upper bits read 0.
  - 0x40: ENABLE, RW, bits [NUM_SRC-1:0].
  - 0x44: PENDING, RO; bit i = 1 when gateway i is in PENDING.
  - 0x48: THRESHOLD, RW, bits [PRIO_W-1:0].
  - 0x4C: CLAIM/COMPLETE. A read claims; a write completes with ID = wdata[4:0].
  - Unmapped offsets read 0; writes to them are ignored.
- Reset values:
  - All PRIO, ENABLE and THRESHOLD = 0.
  - All gateways IDLE.
  - best_id_q = 0, ext_itr = 0, reg_ack = 0, reg_rdata = 0.
- Gateway FSM, one per source, states IDLE / PENDING / INFLIGHT:
  - IDLE -> PENDING at a clock edge where src_irq[i] = 1.
  - PENDING -> INFLIGHT on a claim that returns ID i+1.
  - INFLIGHT -> IDLE on a complete with ID i+1.
  - src_irq is ignored in PENDING and INFLIGHT.
  - A level still high after completion re-pends on the following edge.
  - Disabling a source does not clear PENDING; the source is only masked from arbitration.
- Arbiter:
  - Combinational candidate set: PENDING & ENABLE & (PRIO > THRESHOLD).
  - Winner is the highest PRIO; ties go to the lowest ID.
  - Result is registered into best_id_q (0 if no candidate).
  - ext_itr is a register: 1 exactly when the registered best_id_q != 0.
- Latency:
  - src_irq rises before edge N -> PENDING after N -> ext_itr high after edge N+1, i.e. 2 cycles.
  - Changes to ENABLE, PRIO or THRESHOLD affect ext_itr 1 cycle after the write edge.
- Bus handshake:
  - reg_ack = registered reg_req, so it is high exactly one cycle after each request.
  - reg_rdata is registered in the same way.
  - Back-to-back requests are accepted every cycle.
  - Writes take effect at the request edge.
- Claim read:
  - Returns best_id_q if that gateway is still PENDING; otherwise returns 0 and has no side effect. This guards the stale best_id_q on back-to-back claims.
  - The claimed gateway moves to INFLIGHT at the request edge.
  - ext_itr drops 2 cycles after the claim request unless another candidate exists.
- Complete write:
  - An ID of 0, an ID > NUM_SRC, or an ID whose gateway is not INFLIGHT is ignored silently.
- Simultaneous events:
  - A claim and an IDLE->PENDING transition on a different source in the same edge are both applied.
  - A complete and a src_irq high on the same source in the same edge: the gateway goes to IDLE, then pends on the next edge.
- Reset mid-operation: all gateway state, registers and outputs return to their reset values at the next edge. In-flight claims are discarded.

Decomposition:
- Shared package holy_irq_pkg holds:
  - Register offset localparams: IRQ_PRIO_BASE, IRQ_ENABLE, IRQ_PENDING, IRQ_THRESHOLD, IRQ_CLAIM.
  - The gateway state enum typedef gw_state_t.
- Sub-module irq_gateway, one instance per source, holds the 3-state FSM. Its inputs are src, claim_hit and complete_hit; its outputs are the pending and inflight flags.
- The arbiter tree and register decode live in irq_arbiter.

Test Plan:
- Single source:
  - Setup: PRIO[2]=3, ENABLE=0x04, THRESHOLD=0; pulse src_irq[2].
  - Required: ext_itr high 2 cycles later.
  - Claim read returns 3; ext_itr low 2 cycles after the claim.
  - Complete with 3 -> PENDING reads 0 and the gateway is IDLE.
- Priority and tie:
  - Setup: PRIO[1]=2, PRIO[4]=5, PRIO[6]=5, all enabled and all pending.
  - Required: claims return 5, then 7, then 2; a fourth claim returns 0.
- Threshold/enable:
  - PRIO[0]=2 with THRESHOLD=2 -> ext_itr stays 0; writing THRESHOLD=1 -> ext_itr=1 one cycle later.
  - Clearing ENABLE bit 0 -> ext_itr=0 while PENDING bit 0 stays 1.
- Level re-pend:
  - Hold src_irq[3] high through claim(4) and complete(4).
  - Required: PENDING bit 3 = 0 while INFLIGHT; it returns to 1 one edge after the complete; ext_itr re-asserts.
- Bogus complete and back-to-back claims:
  - Complete with 0, with 9, and with a non-inflight ID -> no state change.
  - Two claims on consecutive cycles with one pending source -> first returns the ID, second returns 0.
- Reset mid-operation:
  - Assert rst while a source is INFLIGHT and ext_itr=1.
  - Required: next cycle PENDING=0, ENABLE=0, ext_itr=0, reg_ack=0.
